// File: rtl/state_table_pkg.sv
// -----------------------------------------------------------------------------
// state_table_pkg
//
// Shared definitions for the state-table sweeper:
//   - sweep_state_t : sequencer FSM states
//   - ROW_W / ERR_W : widths of the row index and the error counter
//   - expected_next : golden next-state/output function of the two-flip-flop
//                     datapath, indexed by a state-table row {A,B,x,y}
// -----------------------------------------------------------------------------
package state_table_pkg;

    localparam int ROW_W = 4;   // {A,B,x,y}
    localparam int ERR_W = 5;   // holds 0..16

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        DONE
    } sweep_state_t;

    // Returns {eA, eB, eZ} for one state-table row.
    //   nextA = x·y' + x·B
    //   nextB = x·A  + x·B'
    //   z     = A
    function automatic logic [2:0] expected_next(input logic [ROW_W-1:0] row);
        logic a;
        logic b;
        logic xi;
        logic yi;
        a  = row[3];
        b  = row[2];
        xi = row[1];
        yi = row[0];
        return {(xi & ~yi) | (xi & b), (xi & a) | (xi & ~b), a};
    endfunction

endpackage

// File: rtl/state_table_model.sv
// -----------------------------------------------------------------------------
// state_table_model
//
// Combinational golden model of the two-flip-flop datapath. Given the row
// currently being exercised it produces the values the datapath is expected
// to present on its next-state and output pins.
//
// Ports:
//   row   in  ROW_W : state-table row {A,B,x,y}
//   exp_a out 1     : expected next-state A
//   exp_b out 1     : expected next-state B
//   exp_z out 1     : expected output z
// -----------------------------------------------------------------------------
module state_table_model
    import state_table_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    output logic             exp_a,
    output logic             exp_b,
    output logic             exp_z
);

    assign {exp_a, exp_b, exp_z} = expected_next(row);

endmodule

// File: rtl/state_table_sweeper.sv
// -----------------------------------------------------------------------------
// state_table_sweeper
//
// Walks all 16 rows of the two-flip-flop datapath's state table in order
// {A,B,x,y} = 0..15. For each row it loads the present state into the
// datapath flip-flops, drives x/y, waits SETTLE_CYCLES, then compares the
// datapath's next-state and output against the golden model. Reports an
// error count, the first failing row and an overall pass flag.
//
// Parameters:
//   SETTLE_CYCLES : cycles between LOAD and CHECK, 0..15
//   STOP_ON_FAIL  : 1 = end the sweep after the first mismatching row
//
// Ports:
//   clk        in  1     : clock
//   reset      in  1     : asynchronous, active-high reset
//   start      in  1     : request a sweep (sampled only in IDLE)
//   busy       out 1     : high in every state except IDLE
//   done       out 1     : one-cycle pulse in DONE
//   pass       out 1     : sweep finished with zero errors (held until next start)
//   ld_en      out 1     : load strobe to the datapath flip-flops
//   ld_val     out 2     : {A,B} present state to load
//   x, y       out 1     : datapath inputs for the current row
//   next_a     in  1     : datapath next-state A
//   next_b     in  1     : datapath next-state B
//   z          in  1     : datapath output
//   cap_en     out 1     : compare-cycle strobe
//   row_idx    out ROW_W : current row {A,B,x,y}
//   err_count  out ERR_W : number of mismatching rows
//   fail_valid out 1     : a mismatch has been seen
//   fail_row   out ROW_W : row of the first mismatch
// -----------------------------------------------------------------------------
module state_table_sweeper
    import state_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             ld_en,
    output logic [1:0]       ld_val,
    output logic             x,
    output logic             y,
    input  logic             next_a,
    input  logic             next_b,
    input  logic             z,
    output logic             cap_en,
    output logic [ROW_W-1:0] row_idx,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [ROW_W-1:0] fail_row
);

    // Terminal value of the settle counter. Only used when SETTLE_CYCLES > 0;
    // with zero settle cycles LOAD goes straight to CHECK.
    localparam logic [3:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    localparam logic [ROW_W-1:0] LAST_ROW = {ROW_W{1'b1}};

    sweep_state_t     state;
    sweep_state_t     state_next;
    logic [3:0]       settle_cnt;

    logic             exp_a;
    logic             exp_b;
    logic             exp_z;
    logic             row_mismatch;
    logic             end_sweep;
    logic [ERR_W-1:0] err_count_after;

    // -------------------------------------------------------------------------
    // Golden model for the row currently being exercised
    // -------------------------------------------------------------------------
    state_table_model u_model (
        .row   (row_idx),
        .exp_a (exp_a),
        .exp_b (exp_b),
        .exp_z (exp_z)
    );

    // The row index itself carries the stimulus: it only changes on the edge
    // leaving CHECK (or on an accepted start), so ld_val/x/y are stable from
    // LOAD through CHECK and simply hold their last values while idle.
    assign ld_val = row_idx[3:2];
    assign x      = row_idx[1];
    assign y      = row_idx[0];

    // Any disagreement on the three observed bits counts once for the row.
    assign row_mismatch = (next_a != exp_a) || (next_b != exp_b) || (z != exp_z);

    assign end_sweep = (row_idx == LAST_ROW) || (STOP_ON_FAIL && row_mismatch);

    // Error total including the row being checked this cycle; used to decide
    // pass on the final row without waiting an extra cycle.
    assign err_count_after = err_count + ERR_W'(row_mismatch);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and strobes
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ld_en      = 1'b0;
        cap_en     = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                ld_en      = 1'b1;
                state_next = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            end

            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = CHECK;
                end
            end

            CHECK: begin
                cap_en     = 1'b1;
                state_next = end_sweep ? DONE : LOAD;
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Row index, settle counter and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_idx    <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_row   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Results of the previous sweep are held until a new
                    // sweep is accepted.
                    if (start) begin
                        row_idx    <= '0;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_row   <= '0;
                    end
                end

                LOAD: begin
                    settle_cnt <= '0;
                end

                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end

                CHECK: begin
                    if (row_mismatch) begin
                        err_count <= err_count_after;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_row   <= row_idx;
                        end
                    end

                    // pass becomes visible in the DONE cycle and is held.
                    // row_idx is not advanced past the final row.
                    if (end_sweep) begin
                        pass <= (err_count_after == '0);
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_state_table_sweeper
//
// Three sweeper instances share one clock and reset:
//   inst 0 : SETTLE_CYCLES=1, STOP_ON_FAIL=0 (fault injected per test)
//   inst 1 : SETTLE_CYCLES=1, STOP_ON_FAIL=1 (next_b stuck-at-0)
//   inst 2 : SETTLE_CYCLES=0, STOP_ON_FAIL=0 (fault-free)
// Each instance drives a behavioural two-flip-flop datapath. Stimulus pushes
// hand-computed expected sweep results into a scoreboard queue; a monitor pops
// and compares whenever an instance pulses done.
// -----------------------------------------------------------------------------
module tb_state_table_sweeper;

    localparam int N        = 3;
    localparam int FLT_NONE = 0;
    localparam int FLT_NB0  = 1;
    localparam int FLT_Z1   = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] start;
    logic [N-1:0] busy;
    logic [N-1:0] done;
    logic [N-1:0] pass;
    logic [N-1:0] ld_en;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] next_a;
    logic [N-1:0] next_b;
    logic [N-1:0] z;
    logic [N-1:0] cap_en;
    logic [N-1:0] fail_valid;
    logic [1:0]   ld_val    [N];
    logic [3:0]   row_idx   [N];
    logic [4:0]   err_count [N];
    logic [3:0]   fail_row  [N];

    logic [N-1:0] ff_a = '0;
    logic [N-1:0] ff_b = '0;
    int           fault [N];

    typedef struct {
        int inst;
        int done_cyc;
        int errs;
        int pass;
        int fv;
        int frow;
        int loads;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    int           ld_cnt [N];
    logic [N-1:0] busy_chk;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- DUTs --
    state_table_sweeper #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .ld_en(ld_en[0]), .ld_val(ld_val[0]), .x(x[0]), .y(y[0]),
        .next_a(next_a[0]), .next_b(next_b[0]), .z(z[0]), .cap_en(cap_en[0]),
        .row_idx(row_idx[0]), .err_count(err_count[0]), .fail_valid(fail_valid[0]),
        .fail_row(fail_row[0])
    );

    state_table_sweeper #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .ld_en(ld_en[1]), .ld_val(ld_val[1]), .x(x[1]), .y(y[1]),
        .next_a(next_a[1]), .next_b(next_b[1]), .z(z[1]), .cap_en(cap_en[1]),
        .row_idx(row_idx[1]), .err_count(err_count[1]), .fail_valid(fail_valid[1]),
        .fail_row(fail_row[1])
    );

    state_table_sweeper #(.SETTLE_CYCLES(0), .STOP_ON_FAIL(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .ld_en(ld_en[2]), .ld_val(ld_val[2]), .x(x[2]), .y(y[2]),
        .next_a(next_a[2]), .next_b(next_b[2]), .z(z[2]), .cap_en(cap_en[2]),
        .row_idx(row_idx[2]), .err_count(err_count[2]), .fail_valid(fail_valid[2]),
        .fail_row(fail_row[2])
    );

    // ------------------------------------------------- behavioural datapath --
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ld_en[i]) begin
                ff_a[i] <= ld_val[i][1];
                ff_b[i] <= ld_val[i][0];
            end
        end
    end

    always_comb begin
        next_a = '0;
        next_b = '0;
        z      = '0;
        for (int i = 0; i < N; i++) begin
            next_a[i] = (x[i] & ~y[i]) | (x[i] & ff_b[i]);
            next_b[i] = (fault[i] == FLT_NB0) ? 1'b0 : ((x[i] & ff_a[i]) | (x[i] & ~ff_b[i]));
            z[i]      = (fault[i] == FLT_Z1) ? 1'b1 : ff_a[i];
        end
    end

    // -------------------------------------------------------------- checker --
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input int i, input string name);
        check(name, 32'({busy[i], done[i], pass[i], ld_en[i], ld_val[i], x[i], y[i],
                         cap_en[i], row_idx[i], err_count[i], fail_valid[i], fail_row[i]}), 32'd0);
    endtask

    // Monitor: row sequence on every load strobe, full result on every done.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) ld_cnt[i] = 0;
            busy_chk = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (busy_chk[i]) begin
                    check($sformatf("busy_after_done[%0d]", i), 32'(busy[i]), 32'd0);
                    busy_chk[i] = 1'b0;
                end
                if (ld_en[i]) begin
                    check($sformatf("row_seq[%0d]", i), 32'(row_idx[i]), 32'(ld_cnt[i]));
                    check($sformatf("ld_fields[%0d]", i), 32'({ld_val[i], x[i], y[i]}), 32'(ld_cnt[i] % 16));
                    ld_cnt[i]++;
                end
                if (done[i]) begin
                    if (sb_q.size() == 0 || sb_q[0].inst != i) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done[%0d]: got done at cycle %0d, expected none", i, cyc);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check($sformatf("done_cycle[%0d]", i), 32'(cyc), 32'(mon_e.done_cyc));
                        check($sformatf("err_count[%0d]", i), 32'(err_count[i]), 32'(mon_e.errs));
                        check($sformatf("pass[%0d]", i), 32'(pass[i]), 32'(mon_e.pass));
                        check($sformatf("fail_valid[%0d]", i), 32'(fail_valid[i]), 32'(mon_e.fv));
                        check($sformatf("fail_row[%0d]", i), 32'(fail_row[i]), 32'(mon_e.frow));
                        check($sformatf("load_count[%0d]", i), 32'(ld_cnt[i]), 32'(mon_e.loads));
                    end
                    ld_cnt[i]   = 0;
                    busy_chk[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus --
    // Pulses start on instance i for one edge; s is the cycle count just after
    // the sampling edge, i.e. the count seen during the LOAD cycle of row 0.
    task automatic pulse_start(input int i, output int s);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        s = cyc;
    endtask

    task automatic push(input int i, input int done_cyc, input int errs, input int p,
                        input int fv, input int frow, input int loads);
        exp_t e;
        e.inst = i; e.done_cyc = done_cyc; e.errs = errs; e.pass = p;
        e.fv = fv; e.frow = frow; e.loads = loads;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({"drain_", name}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int s;
        int s_dummy;
        reset = 1'b1;
        start = '0;
        for (int i = 0; i < N; i++) fault[i] = FLT_NONE;
        fault[1] = FLT_NB0;
        #1;
        for (int i = 0; i < N; i++) check_zero(i, $sformatf("reset_state[%0d]", i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fault-free sweep, S=1: done 49 cycles after start.
        pulse_start(0, s);
        push(0, s + 48, 0, 1, 0, 0, 16);
        wait_drain("clean", 200);

        // next_b stuck-at-0: rows 2,3,10,11,14,15 fail.
        fault[0] = FLT_NB0;
        pulse_start(0, s);
        push(0, s + 48, 6, 0, 1, 2, 16);
        wait_drain("nb0", 200);

        // Same fault with STOP_ON_FAIL: ends after row 2.
        pulse_start(1, s);
        push(1, s + 9, 1, 0, 1, 2, 3);
        wait_drain("nb0_stop", 200);

        // z tied high: rows 0..7 fail.
        fault[0] = FLT_Z1;
        pulse_start(0, s);
        push(0, s + 48, 8, 0, 1, 0, 16);
        wait_drain("z1", 200);

        // start re-pulsed during row 5 is ignored.
        fault[0] = FLT_NONE;
        pulse_start(0, s);
        push(0, s + 48, 0, 1, 0, 0, 16);
        repeat (15) @(posedge clk);
        pulse_start(0, s_dummy);
        wait_drain("restart_ignored", 200);

        // start held high: second sweep's LOAD follows done after one IDLE cycle.
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        push(0, s + 48, 0, 1, 0, 0, 16);
        push(0, s + 98, 0, 1, 0, 0, 16);
        repeat (55) @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_drain("start_held", 200);

        // Reset during row 7 on the S=0 instance: immediate clear, no done.
        pulse_start(2, s);
        repeat (14) @(posedge clk);
        #2;
        check("pre_reset_row", 32'(row_idx[2]), 32'd7);
        check("pre_reset_busy", 32'(busy[2]), 32'd1);
        reset = 1'b1;
        #1;
        check_zero(2, "mid_sweep_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);

        // Fresh sweep after reset, S=0: done 33 cycles after start.
        pulse_start(2, s);
        push(2, s + 32, 0, 1, 0, 0, 16);
        wait_drain("fast_after_reset", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
